// File: rtl/prt_dp_lib_cdc_arb_rst.sv
// Reset synchronizer for the destination clock domain.
// Purpose : assert reset asynchronously, release it synchronously.
// Ports   : clk  - destination clock
//           arst - asynchronous active-high reset from the source side
//           rst  - synchronized active-high reset for the clk domain
module prt_dp_lib_cdc_arb_rst #(
    parameter int P_STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    output logic rst
);

    (* syn_preserve = 1 *) logic [P_STAGES-1:0] cdc_arb_rst_sync;

    // Ones flush out after P_STAGES clean clock edges once arst drops.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cdc_arb_rst_sync <= '1;
        end else begin
            cdc_arb_rst_sync <= {cdc_arb_rst_sync[P_STAGES-2:0], 1'b0};
        end
    end

    assign rst = cdc_arb_rst_sync[P_STAGES-1];

endmodule

// File: rtl/prt_dp_lib_cdc_arb.sv
// Round-robin arbiter that moves one payload at a time from the source
// clock domain to the destination clock domain with a toggle handshake.
// Ports   : SRC_CLK_IN, prt_dp_lib_sclk_rst - source clock, async reset
//           SRC_REQ_IN/SRC_DAT_IN           - per-requester request/payload
//           SRC_ACK_OUT                     - per-requester delivery pulse
//           SRC_BUSY_OUT                    - transfer outstanding
//           DST_CLK_IN                      - destination clock
//           DST_DAT_OUT/DST_ID_OUT          - delivered payload and index
//           DST_VLD_OUT                     - one-cycle delivery qualifier
module prt_dp_lib_cdc_arb #(
    parameter int P_REQ    = 4,
    parameter int P_WIDTH  = 16,
    parameter int P_STAGES = 2
) (
    input  logic                       SRC_CLK_IN,
    input  logic                       prt_dp_lib_sclk_rst,
    input  logic                       DST_CLK_IN,
    input  logic [P_REQ-1:0]           SRC_REQ_IN,
    input  logic [P_REQ*P_WIDTH-1:0]   SRC_DAT_IN,
    output logic [P_REQ-1:0]           SRC_ACK_OUT,
    output logic                       SRC_BUSY_OUT,
    output logic [P_WIDTH-1:0]         DST_DAT_OUT,
    output logic [$clog2(P_REQ)-1:0]   DST_ID_OUT,
    output logic                       DST_VLD_OUT
);

    localparam int ID_W = $clog2(P_REQ);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Source domain
    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   pick;
    logic              found;
    logic              req_tgl;
    logic [P_REQ-1:0]  ack_q;
    logic              busy_q;

    // Read by the destination domain; static while a transfer is open.
    (* syn_preserve = 1 *) logic [P_WIDTH-1:0] cdc_arb_hold_dat;
    (* syn_preserve = 1 *) logic [ID_W-1:0]    cdc_arb_hold_id;
    (* syn_preserve = 1 *) logic [P_STAGES-1:0] cdc_arb_src_ack_sync;

    // Destination domain
    logic              dst_rst;
    logic              req_seen;
    logic              ack_tgl;
    logic              vld_q;
    logic [P_WIDTH-1:0] dat_q;
    logic [ID_W-1:0]   id_q;

    (* syn_preserve = 1 *) logic [P_STAGES-1:0] cdc_arb_dst_req_sync;

    // Search starts one past the last winner so every requester rotates.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        for (int i = 1; i <= P_REQ; i++) begin
            if (!found && SRC_REQ_IN[(int'(last_grant) + i) % P_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(last_grant) + i) % P_REQ);
            end
        end
    end

    always_ff @(posedge SRC_CLK_IN or posedge prt_dp_lib_sclk_rst) begin
        if (prt_dp_lib_sclk_rst) begin
            state            <= ST_IDLE;
            last_grant       <= ID_W'(P_REQ - 1);
            cdc_arb_hold_dat <= '0;
            cdc_arb_hold_id  <= '0;
            req_tgl          <= 1'b0;
            ack_q            <= '0;
            busy_q           <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (found) begin
                        cdc_arb_hold_dat <= SRC_DAT_IN[int'(pick)*P_WIDTH +: P_WIDTH];
                        cdc_arb_hold_id  <= pick;
                        req_tgl          <= ~req_tgl;
                        busy_q           <= 1'b1;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cdc_arb_src_ack_sync[P_STAGES-1] == req_tgl) begin
                        ack_q      <= P_REQ'(1) << cdc_arb_hold_id;
                        last_grant <= cdc_arb_hold_id;
                        busy_q     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SRC_CLK_IN or posedge prt_dp_lib_sclk_rst) begin
        if (prt_dp_lib_sclk_rst) begin
            cdc_arb_src_ack_sync <= '0;
        end else begin
            cdc_arb_src_ack_sync <= {cdc_arb_src_ack_sync[P_STAGES-2:0], ack_tgl};
        end
    end

    assign SRC_ACK_OUT  = ack_q;
    assign SRC_BUSY_OUT = busy_q;

    prt_dp_lib_cdc_arb_rst #(
        .P_STAGES (P_STAGES)
    ) u_rst (
        .clk  (DST_CLK_IN),
        .arst (prt_dp_lib_sclk_rst),
        .rst  (dst_rst)
    );

    // One delivery per toggle change of the synchronized request.
    always_ff @(posedge DST_CLK_IN or posedge dst_rst) begin
        if (dst_rst) begin
            cdc_arb_dst_req_sync <= '0;
            req_seen             <= 1'b0;
            ack_tgl              <= 1'b0;
            vld_q                <= 1'b0;
            dat_q                <= '0;
            id_q                 <= '0;
        end else begin
            cdc_arb_dst_req_sync <= {cdc_arb_dst_req_sync[P_STAGES-2:0], req_tgl};
            req_seen             <= cdc_arb_dst_req_sync[P_STAGES-1];
            vld_q                <= 1'b0;
            if (cdc_arb_dst_req_sync[P_STAGES-1] != req_seen) begin
                dat_q   <= cdc_arb_hold_dat;
                id_q    <= cdc_arb_hold_id;
                vld_q   <= 1'b1;
                ack_tgl <= ~ack_tgl;
            end
        end
    end

    assign DST_DAT_OUT = dat_q;
    assign DST_ID_OUT  = id_q;
    assign DST_VLD_OUT = vld_q;

endmodule
